cam_frame_writer: RTL and testbench
===================================

Name: cam_frame_writer

Overview:
Downstream of the camera capture stage, in the pclk domain. Consumes the capture stage's pixel stream (x_coord, y_coord, pixel_data, pixel_valid), decimates it by DS in both axes, and writes the kept pixels into a double-buffered frame-buffer BRAM write port. Swaps banks at each frame boundary, pulses frame_done, and defers the swap while the display side holds the readable bank.

Parameters:
IN_W, 640, input columns per row.
IN_H, 480, input rows per frame.
DS, 2, decimation factor; legal values 1, 2, 4.
ADDR_W, 17, write-address width; must be >= clog2((IN_W/DS)*(IN_H/DS)).

Ports:
pclk  in  1  camera pixel clock; the only clock.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  capture enable; sampled in S_WAIT and S_WRITE.
x_coord  in  10  1-based column of the pixel accompanying pixel_valid (column index = x_coord-1).
y_coord  in  10  0-based row; returns to 0 at each frame start.
pixel_data  in  8  grayscale pixel.
pixel_valid  in  1  single-cycle strobe; pixel_data/x_coord are valid.
swap_hold  in  1  display is reading disp_bank; the swap must not occur while high.
wr_en  out  1  BRAM write strobe.
wr_bank  out  1  bank being written.
wr_addr  out  ADDR_W  word address within the bank.
wr_data  out  8  pixel to write.
disp_bank  out  1  bank holding the last complete frame; always ~wr_bank.
frame_done  out  1  one-cycle pulse on each bank swap.
drop_count  out  8  saturating count of frames lost to swap_hold.

Behaviour:
- Reset (async, reset_n low): state=S_WAIT, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, disp_bank=1, frame_done=0, drop_count=0, y_q=0. Mid-frame reset abandons the frame; no swap, no frame_done.
- y_q: registered copy of y_coord, updated every cycle. boundary = (y_coord==0) && (y_q!=0).
- Pixel keep rule: col=x_coord-1, row=y_coord; keep iff pixel_valid && col<IN_W && row<IN_H && col%DS==0 && row%DS==0. x_coord==0 with pixel_valid is treated as out of range (dropped).
- Address: wr_addr = (row/DS)*(IN_W/DS) + col/DS, truncated to ADDR_W. DS is a power of 2; divides are shifts.
- Latency: a kept pixel at cycle N gives wr_en=1 with wr_addr/wr_data/wr_bank at cycle N+1. wr_en is high for exactly one cycle per kept pixel. wr_addr/wr_data hold their last values when wr_en=0.
- S_WAIT: no writes. If boundary && enable: go to S_WRITE. A pixel_valid in the boundary cycle is processed under S_WRITE rules.
- S_WRITE: write kept pixels.
  - enable low: go to S_WAIT immediately; the partial frame is discarded with no swap. enable low has priority over boundary.
  - boundary && !swap_hold: toggle wr_bank and disp_bank and pulse frame_done next cycle; stay in S_WRITE. A kept pixel in the boundary cycle is written to the NEW bank.
  - boundary && swap_hold: go to S_HOLD and increment drop_count (saturating at 255); the boundary-cycle pixel is not written.
- S_HOLD: no writes. When swap_hold goes low: swap banks, pulse frame_done, go to S_WAIT. This holds even if a boundary occurs in the same cycle; the frame starting in that cycle is skipped.
- frame_done is registered; it is never high for two consecutive cycles.
- disp_bank == ~wr_bank at all times, including reset.

Test Plan:
1. IN_W=8, IN_H=4, DS=2. Reset, then drive two full frames (y goes 3->0 to start each) with enable=1, swap_hold=0 -> first boundary moves to S_WRITE; frame 1 gives 8 writes with addr 0..7 in order to bank 0, data matching pixels at even col/row; at the next boundary frame_done pulses once, wr_bank=1, disp_bank=0.
2. Pixel at x_coord=3, y_coord=2 (col 2, row 2), data 0xA5 -> one cycle later wr_en=1, wr_addr=5, wr_data=0xA5. Odd row or col -> no write.
3. swap_hold=1 at boundary -> no swap, drop_count=1, no writes during hold; swap_hold drops 10 cycles later -> frame_done pulses the next cycle, banks toggle, state S_WAIT; next boundary resumes writing.
4. enable deasserted mid-frame -> wr_en stays 0 from the next cycle; no frame_done at the following boundary; re-enable -> writing resumes only after a boundary.
5. reset_n asserted mid-row with wr_en high -> all outputs reach reset values immediately (asynchronously); after release, no writes before a boundary.
6. Force drop_count to 255 via repeated held swaps -> drop_count stays at 255; frame_done never high for two consecutive cycles.

Source files
------------

// File: rtl/cam_frame_writer.sv
// Decimating frame-buffer writer: keeps every DS-th pixel of every DS-th row
// of the capture stream and writes it into one bank of a double-buffered BRAM.
// Banks swap at frame boundaries unless the display side is holding the
// readable bank, in which case the frame is dropped and counted.
module cam_frame_writer #(
  parameter int unsigned IN_W   = 640,
  parameter int unsigned IN_H   = 480,
  parameter int unsigned DS     = 2,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [9:0]        x_coord,
  input  logic [9:0]        y_coord,
  input  logic [7:0]        pixel_data,
  input  logic              pixel_valid,
  input  logic              swap_hold,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              disp_bank,
  output logic              frame_done,
  output logic [7:0]        drop_count
);

  localparam int unsigned OutW    = IN_W / DS;
  localparam int unsigned DsMask  = DS - 1;
  localparam int unsigned DsShift = $clog2(DS);

  typedef enum logic [1:0] {StWait, StWrite, StHold} state_e;

  state_e      state_q;
  logic [9:0]  y_q;
  logic [10:0] col;
  logic        boundary;
  logic        keep;
  logic [31:0] addr_full;
  logic [ADDR_W-1:0] next_addr;

  // x_coord is 1-based; x_coord==0 wraps col to all-ones and is rejected explicitly
  assign col = {1'b0, x_coord} - 11'd1;

  // Frame start: row counter has just returned to zero
  assign boundary = (y_coord == 10'd0) && (y_q != 10'd0);

  // Keep/address decode for the pixel presented this cycle
  always_comb begin
    keep = pixel_valid && (x_coord != 10'd0) && (32'(col) < IN_W) && (32'(y_coord) < IN_H)
           && ((32'(col) & DsMask) == 32'd0) && ((32'(y_coord) & DsMask) == 32'd0);
    addr_full = (32'(y_coord) >> DsShift) * OutW + (32'(col) >> DsShift);
    next_addr = addr_full[ADDR_W-1:0];
  end

  // Row history, used only for boundary detection
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) y_q <= 10'd0;
    else          y_q <= y_coord;
  end

  // Control FSM with registered write port, bank select and status outputs
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StWait;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      wr_bank    <= 1'b0;
      disp_bank  <= 1'b1;
      frame_done <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      unique case (state_q)
        StWait: begin
          // Entering on a boundary starts the frame in the current bank, no swap
          if (boundary && enable) begin
            state_q <= StWrite;
            if (keep) begin
              wr_en   <= 1'b1;
              wr_addr <= next_addr;
              wr_data <= pixel_data;
            end
          end
        end
        StWrite: begin
          if (!enable) begin
            state_q <= StWait;
          end else if (boundary && swap_hold) begin
            state_q <= StHold;
            if (drop_count != 8'hff) drop_count <= drop_count + 8'd1;
          end else begin
            if (boundary) begin
              // Registered bank flips with wr_en, so this pixel lands in the new bank
              wr_bank    <= ~wr_bank;
              disp_bank  <= ~disp_bank;
              frame_done <= 1'b1;
            end
            if (keep) begin
              wr_en   <= 1'b1;
              wr_addr <= next_addr;
              wr_data <= pixel_data;
            end
          end
        end
        StHold: begin
          // Late swap; a frame starting this same cycle is skipped via StWait
          if (!swap_hold) begin
            wr_bank    <= ~wr_bank;
            disp_bank  <= ~disp_bank;
            frame_done <= 1'b1;
            state_q    <= StWait;
          end
        end
        default: state_q <= StWait;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer on a small 8x4 frame with DS=2.
module tb_cam_frame_writer;

  localparam int unsigned AW = 17;

  logic          pclk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [9:0]    x_coord;
  logic [9:0]    y_coord;
  logic [7:0]    pixel_data;
  logic          pixel_valid;
  logic          swap_hold;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          disp_bank;
  logic          frame_done;
  logic [7:0]    drop_count;

  int n_pass  = 0;
  int n_total = 0;
  logic prev_fd = 1'b0;

  cam_frame_writer #(
    .IN_W  (8),
    .IN_H  (4),
    .DS    (2),
    .ADDR_W(AW)
  ) dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .x_coord    (x_coord),
    .y_coord    (y_coord),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .swap_hold  (swap_hold),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_bank  (disp_bank),
    .frame_done (frame_done),
    .drop_count (drop_count)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one pixel for one cycle; returns #1 after the edge that consumed it
  task automatic pix(input int x, input int y, input int d, input int v);
    @(negedge pclk);
    x_coord     = 10'(x);
    y_coord     = 10'(y);
    pixel_data  = 8'(d);
    pixel_valid = v[0];
    @(posedge pclk);
    #1;
    chk("fd_consecutive", {31'd0, frame_done & prev_fd}, 32'd0);
    prev_fd = frame_done;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_wr_bank"}, {31'd0, wr_bank}, 32'd0);
    chk({tag, "_disp_bank"}, {31'd0, disp_bank}, 32'd1);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
  endtask

  // Full 8x4 frame; first pixel is the boundary cycle
  task automatic run_frame(input bit exp_fd, input bit bank, input string tag);
    int nw = 0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 1; x <= 8; x++) begin
        bit k = ((x - 1) % 2 == 0) && (y % 2 == 0);
        pix(x, y, y * 16 + x, 1);
        if (y == 0 && x == 1) begin
          chk({tag, "_frame_done"}, {31'd0, frame_done}, {31'd0, exp_fd});
          chk({tag, "_disp_bank"}, {31'd0, disp_bank}, {31'd0, ~bank});
        end
        chk({tag, "_wr_en"}, {31'd0, wr_en}, {31'd0, k});
        if (k) begin
          chk({tag, "_wr_addr"}, 32'(wr_addr), 32'((y / 2) * 4 + (x - 1) / 2));
          chk({tag, "_wr_data"}, 32'(wr_data), 32'(y * 16 + x));
          chk({tag, "_wr_bank"}, {31'd0, wr_bank}, {31'd0, bank});
        end
        nw += int'(wr_en);
      end
    end
    chk({tag, "_nwrites"}, 32'(nw), 32'd8);
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b1;
    swap_hold   = 1'b0;
    x_coord     = 10'd0;
    y_coord     = 10'd0;
    pixel_data  = 8'd0;
    pixel_valid = 1'b0;
    repeat (2) @(negedge pclk);
    reset_n = 1'b1;
    @(posedge pclk);
    #1;
    reset_chk("reset");

    // 1: enter on first boundary, fill bank 0, then swap into bank 1
    pix(0, 3, 0, 0);
    chk("t1_wait_wr_en", {31'd0, wr_en}, 32'd0);
    run_frame(1'b0, 1'b0, "t1_f1");
    run_frame(1'b1, 1'b1, "t1_f2");

    // 2: single directed pixel, then odd col/row rejected with address held
    pix(3, 2, 8'hA5, 1);
    chk("t2_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t2_wr_addr", 32'(wr_addr), 32'd5);
    chk("t2_wr_data", 32'(wr_data), 32'hA5);
    pix(4, 2, 8'h5A, 1);
    chk("t2_oddcol_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t2_hold_addr", 32'(wr_addr), 32'd5);
    chk("t2_hold_data", 32'(wr_data), 32'hA5);
    pix(3, 3, 8'h77, 1);
    chk("t2_oddrow_wr_en", {31'd0, wr_en}, 32'd0);
    pix(0, 2, 8'h66, 1);
    chk("t2_x0_wr_en", {31'd0, wr_en}, 32'd0);
    pix(0, 3, 0, 0);

    // 3: boundary under swap_hold drops the frame until release
    swap_hold = 1'b1;
    pix(1, 0, 8'h11, 1);
    chk("t3_hold_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t3_hold_drop", 32'(drop_count), 32'd1);
    chk("t3_hold_fd", {31'd0, frame_done}, 32'd0);
    chk("t3_hold_bank", {31'd0, wr_bank}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      pix(3, 0, 8'h22, 1);
      chk("t3_held_wr_en", {31'd0, wr_en}, 32'd0);
    end
    swap_hold = 1'b0;
    pix(5, 0, 8'h33, 1);
    chk("t3_release_fd", {31'd0, frame_done}, 32'd1);
    chk("t3_release_bank", {31'd0, wr_bank}, 32'd0);
    chk("t3_release_disp", {31'd0, disp_bank}, 32'd1);
    chk("t3_release_wr_en", {31'd0, wr_en}, 32'd0);
    pix(1, 2, 8'h44, 1);
    chk("t3_wait_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t3_wait_fd", {31'd0, frame_done}, 32'd0);
    pix(0, 3, 0, 0);
    run_frame(1'b0, 1'b0, "t3_resume");

    // 4: enable drop discards the frame; re-enable waits for a boundary
    run_frame(1'b1, 1'b1, "t4_pre");
    enable = 1'b0;
    pix(1, 0, 8'h55, 0);
    pix(3, 2, 8'h56, 1);
    chk("t4_dis_wr_en", {31'd0, wr_en}, 32'd0);
    pix(1, 0, 8'h57, 1);
    chk("t4_dis_bnd_fd", {31'd0, frame_done}, 32'd0);
    chk("t4_dis_bnd_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t4_dis_bnd_bank", {31'd0, wr_bank}, 32'd1);
    enable = 1'b1;
    pix(3, 0, 8'h58, 1);
    chk("t4_reen_wr_en", {31'd0, wr_en}, 32'd0);
    pix(1, 2, 8'h59, 1);
    chk("t4_reen2_wr_en", {31'd0, wr_en}, 32'd0);
    pix(0, 3, 0, 0);
    run_frame(1'b0, 1'b1, "t4_resume");

    // 5: asynchronous reset while a write is in flight
    pix(1, 0, 8'h33, 1);
    chk("t5_pre_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t5_pre_bank", {31'd0, wr_bank}, 32'd0);
    #1 reset_n = 1'b0;
    #1 reset_chk("t5_async");
    #1 reset_n = 1'b1;
    pix(3, 0, 8'h34, 1);
    chk("t5_post_wr_en", {31'd0, wr_en}, 32'd0);
    pix(1, 2, 8'h35, 1);
    chk("t5_post2_wr_en", {31'd0, wr_en}, 32'd0);
    pix(0, 3, 0, 0);
    run_frame(1'b0, 1'b0, "t5_resume");

    // 6: repeated held swaps saturate drop_count
    for (int i = 0; i < 256; i++) begin
      swap_hold = 1'b1;
      pix(1, 0, 8'h01, 1);
      if (i == 253) chk("t6_drop_254", 32'(drop_count), 32'd254);
      if (i == 254) chk("t6_drop_255", 32'(drop_count), 32'd255);
      swap_hold = 1'b0;
      pix(1, 1, 0, 0);
      pix(1, 0, 8'h02, 1);
      pix(1, 1, 0, 0);
    end
    chk("t6_drop_sat", 32'(drop_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
